// File: rtl/pcie_pkg.sv
// pcie_pkg: shared types and constants for PIPE receiver detection.
// Holds the detect FSM state enum and the PIPE encodings it relies on.
package pcie_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ASSERT = 3'd1,
        WAIT   = 3'd2,
        EVAL   = 3'd3,
        DONE   = 3'd4
    } detState_t;

    localparam logic [2:0] RXSTATUS_DETECTED = 3'b011;
    localparam logic [3:0] POWERDOWN_P1      = 4'h2;

endpackage

// File: rtl/pcie_lane_width_calc.sv
// pcie_lane_width_calc: lane population count and usable link width.
// Ports: mask (detected lanes) -> laneCount, linkWidth (power of two).
module pcie_lane_width_calc #(
    parameter int  LANESNUMBER = 16,
    localparam int LW          = $clog2(LANESNUMBER) + 1
) (
    input  logic [LANESNUMBER-1:0] mask,
    output logic [LW-1:0]          laneCount,
    output logic [LW-1:0]          linkWidth
);

    logic prefixAll;

    always_comb begin
        laneCount = '0;
        linkWidth = '0;
        prefixAll = 1'b1;
        for (int i = 0; i < LANESNUMBER; i++) begin
            laneCount = laneCount + LW'(mask[i]);
            prefixAll = prefixAll & mask[i];
            // a width is only usable at a power-of-two lane count
            if (prefixAll && (((i + 1) & i) == 0)) begin
                linkWidth = LW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/pcie_rx_detect_ctrl.sv
// pcie_rx_detect_ctrl: PIPE receiver-detect sequencer with retry/timeout.
// Ports: pclk/reset_n, start/restart in, PhyStatus/RxStatus from PHY,
// TxDetectRx_Loopback/TxElecIdle/PowerDown to PHY, detect results out.
module pcie_rx_detect_ctrl
    import pcie_pkg::*;
#(
    parameter int  LANESNUMBER    = 16,
    parameter int  TIMEOUT_CYCLES = 1024,
    parameter int  MAX_RETRIES    = 2,
    localparam int LW             = $clog2(LANESNUMBER) + 1
) (
    input  logic                     pclk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     restart,
    input  logic [LANESNUMBER-1:0]   PhyStatus,
    input  logic [3*LANESNUMBER-1:0] RxStatus,
    output logic [LANESNUMBER-1:0]   TxDetectRx_Loopback,
    output logic [LANESNUMBER-1:0]   TxElecIdle,
    output logic [4*LANESNUMBER-1:0] PowerDown,
    output logic [LANESNUMBER-1:0]   detected_mask,
    output logic [LW-1:0]            NumberDetectLanes,
    output logic [LW-1:0]            link_width,
    output logic                     WriteDetectLanesFlag,
    output logic                     busy,
    output logic                     timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    detState_t state, stateNext;
    logic [CW-1:0] winCnt, winCntNext;
    logic [RW-1:0] retryCnt, retryCntNext;
    logic [LANESNUMBER-1:0] responded, respondedNext;
    logic [LANESNUMBER-1:0] maskNext, rxHit, phyNew;
    logic [LW-1:0] calcCount, calcWidth, countNext, widthNext;
    logic timeoutNext;

    // the link stays electrically idle in P1 throughout detection
    assign TxElecIdle = '1;
    assign PowerDown  = {LANESNUMBER{POWERDOWN_P1}};

    for (genvar i = 0; i < LANESNUMBER; i++) begin : gLane
        assign rxHit[i] = (RxStatus[3*i +: 3] == RXSTATUS_DETECTED);
    end

    // only the first strobe of a lane in a window carries its result
    assign phyNew = PhyStatus & ~responded;

    pcie_lane_width_calc #(
        .LANESNUMBER(LANESNUMBER)
    ) uWidthCalc (
        .mask      (detected_mask),
        .laneCount (calcCount),
        .linkWidth (calcWidth)
    );

    always_comb begin
        stateNext     = state;
        winCntNext    = winCnt;
        retryCntNext  = retryCnt;
        respondedNext = responded;
        maskNext      = detected_mask;
        timeoutNext   = timeout;
        countNext     = NumberDetectLanes;
        widthNext     = link_width;
        unique case (state)
            IDLE: begin
                if (start || restart) begin
                    stateNext     = ASSERT;
                    winCntNext    = '0;
                    retryCntNext  = '0;
                    respondedNext = '0;
                    maskNext      = '0;
                    timeoutNext   = 1'b0;
                    countNext     = '0;
                    widthNext     = '0;
                end
            end
            ASSERT: stateNext = WAIT;
            WAIT: begin
                respondedNext = responded | PhyStatus;
                maskNext      = detected_mask | (phyNew & rxHit);
                winCntNext    = winCnt + CW'(1);
                // all-responded wins over a coincident window expiry
                if (&respondedNext) begin
                    stateNext = EVAL;
                end else if (winCnt == CNT_LAST) begin
                    stateNext   = EVAL;
                    timeoutNext = 1'b1;
                end
            end
            EVAL: begin
                if (detected_mask == '0 && retryCnt < RETRY_MAX) begin
                    stateNext     = ASSERT;
                    retryCntNext  = retryCnt + RW'(1);
                    winCntNext    = '0;
                    respondedNext = '0;
                end else begin
                    stateNext = DONE;
                    countNext = calcCount;
                    widthNext = calcWidth;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // a forced restart overrides whatever exit was chosen above
        if (restart && (state inside {ASSERT, WAIT, EVAL})) begin
            stateNext     = ASSERT;
            winCntNext    = '0;
            retryCntNext  = '0;
            respondedNext = '0;
            maskNext      = '0;
            timeoutNext   = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            winCnt               <= '0;
            retryCnt             <= '0;
            responded            <= '0;
            detected_mask        <= '0;
            NumberDetectLanes    <= '0;
            link_width           <= '0;
            timeout              <= 1'b0;
            WriteDetectLanesFlag <= 1'b0;
            busy                 <= 1'b0;
            TxDetectRx_Loopback  <= '0;
        end else begin
            state                <= stateNext;
            winCnt               <= winCntNext;
            retryCnt             <= retryCntNext;
            responded            <= respondedNext;
            detected_mask        <= maskNext;
            NumberDetectLanes    <= countNext;
            link_width           <= widthNext;
            timeout              <= timeoutNext;
            WriteDetectLanesFlag <= (stateNext == DONE);
            busy                 <= (stateNext != IDLE);
            TxDetectRx_Loopback  <= {LANESNUMBER{stateNext == WAIT}};
        end
    end

endmodule

// File: tb/tb_pcie_rx_detect_ctrl.sv
// tb_pcie_rx_detect_ctrl: scenario bench for the receiver-detect sequencer.
// Drives per-window lane response schedules and checks a window-level model.
module tb_pcie_rx_detect_ctrl;

    localparam int L  = 16;
    localparam int T  = 16;
    localparam int R  = 2;
    localparam int LW = $clog2(L) + 1;

    logic pclk = 1'b0;
    logic reset_n, start, restart;
    logic [L-1:0]   PhyStatus;
    logic [3*L-1:0] RxStatus;
    logic [L-1:0]   TxDetectRx_Loopback, TxElecIdle, detected_mask;
    logic [4*L-1:0] PowerDown;
    logic [LW-1:0]  NumberDetectLanes, link_width;
    logic WriteDetectLanesFlag, busy, timeout;

    int nChecks = 0;
    int nFails  = 0;

    // per-window lane schedule: first-response cycle (-1 = never) and RxStatus
    int       respCyc[3][L];
    logic [2:0] rxVal[3][L];

    // model expectations
    logic [L-1:0] expMask;
    int expWins, expLat;
    int expLen[3];
    bit expTo;

    always #5 pclk = ~pclk;

    pcie_rx_detect_ctrl #(
        .LANESNUMBER(L), .TIMEOUT_CYCLES(T), .MAX_RETRIES(R)
    ) dut (
        .pclk(pclk), .reset_n(reset_n), .start(start), .restart(restart),
        .PhyStatus(PhyStatus), .RxStatus(RxStatus),
        .TxDetectRx_Loopback(TxDetectRx_Loopback), .TxElecIdle(TxElecIdle),
        .PowerDown(PowerDown), .detected_mask(detected_mask),
        .NumberDetectLanes(NumberDetectLanes), .link_width(link_width),
        .WriteDetectLanesFlag(WriteDetectLanesFlag), .busy(busy),
        .timeout(timeout)
    );

    function automatic int expWidth(input logic [L-1:0] m);
        int w;
        int pm;
        w = 0;
        for (int n = 1; n <= L; n = n * 2) begin
            pm = (1 << n) - 1;
            if ((int'(m) & pm) == pm) w = n;
            else break;
        end
        return w;
    endfunction

    // window-level model: each window ends at the last first-response,
    // or after T cycles if some lane stays silent
    task automatic model();
        int last, e;
        bit all;
        expTo = 0; expLat = 0; expWins = 0; expMask = '0;
        for (int w = 0; w <= R; w++) begin
            last = -1; all = 1;
            for (int i = 0; i < L; i++) begin
                if (respCyc[w][i] >= 0 && respCyc[w][i] < T) begin
                    if (respCyc[w][i] > last) last = respCyc[w][i];
                end else all = 0;
            end
            e = all ? last : T - 1;
            if (!all) expTo = 1;
            expMask = '0;
            for (int i = 0; i < L; i++)
                if (respCyc[w][i] >= 0 && respCyc[w][i] <= e
                    && rxVal[w][i] == 3'b011) expMask[i] = 1'b1;
            expLen[w] = e + 1;
            expLat += e + 3;
            expWins = w + 1;
            if (expMask != '0) break;
        end
    endtask

    task automatic clear_inputs();
        PhyStatus = '0; RxStatus = '0; start = 0; restart = 0;
    endtask

    task automatic set_window(input int w, input int cyc, input logic [2:0] rx);
        for (int i = 0; i < L; i++) begin
            respCyc[w][i] = cyc; rxVal[w][i] = rx;
        end
    endtask

    task automatic run_txn(input string nm, input bit useRestart,
                           input bit spur, input bit noise);
        int k, w, flagAt, flagCnt, lim;
        int lenQ[$];
        bit prevTx, badIdle, badBusy;
        logic [L-1:0] obsMask;
        logic [LW-1:0] obsCnt, obsWid;
        logic obsTo;
        model();
        clear_inputs();
        @(posedge pclk); #1;
        if (useRestart) restart = 1; else start = 1;
        @(posedge pclk); #1;
        start = 0; restart = 0;
        k = 0; flagAt = -1; flagCnt = 0; prevTx = 0;
        badIdle = 0; badBusy = 0; lim = expLat + 4 * T + 20;
        obsMask = '0; obsCnt = '0; obsWid = '0; obsTo = 0;
        for (int n = 0; n < lim; n++) begin
            if (TxElecIdle !== '1 || PowerDown !== {L{4'h2}}) badIdle = 1;
            if (flagAt < 0 && busy !== 1'b1) badBusy = 1;
            if (WriteDetectLanesFlag === 1'b1) begin
                flagCnt++;
                if (flagAt < 0) begin
                    flagAt = n;
                    obsMask = detected_mask; obsCnt = NumberDetectLanes;
                    obsWid = link_width; obsTo = timeout;
                end
            end
            if (flagAt >= 0 && n == flagAt + 1) break;
            if (TxDetectRx_Loopback[0] === 1'b1) begin
                if (!prevTx) k = 0;
                w = lenQ.size();
                PhyStatus = '0;
                for (int i = 0; i < L; i++) begin
                    RxStatus[3*i +: 3] = 3'($urandom_range(0, 7));
                    if (w < 3 && respCyc[w][i] == k) begin
                        PhyStatus[i] = 1'b1;
                        RxStatus[3*i +: 3] = rxVal[w][i];
                    end else if (spur && w < 3 && respCyc[w][i] >= 0
                                 && respCyc[w][i] < k
                                 && $urandom_range(0, 3) == 0) begin
                        PhyStatus[i] = 1'b1;
                        RxStatus[3*i +: 3] =
                            (rxVal[w][i] == 3'b011) ? 3'b000 : 3'b011;
                    end
                end
                start = noise && ($urandom_range(0, 4) == 0);
                k++;
                prevTx = 1;
            end else begin
                if (prevTx) lenQ.push_back(k);
                prevTx = 0;
                PhyStatus = '0; RxStatus = '0; start = 0;
            end
            @(posedge pclk); #1;
        end
        clear_inputs();

        nChecks++;
        if (flagAt !== expLat) begin
            nFails++;
            $display("FAIL %s latency: got %0d want %0d", nm, flagAt, expLat);
        end
        nChecks++;
        if (flagCnt !== 1) begin
            nFails++;
            $display("FAIL %s flag_pulses: got %0d want 1", nm, flagCnt);
        end
        nChecks++;
        if (obsMask !== expMask) begin
            nFails++;
            $display("FAIL %s mask: got %h want %h", nm, obsMask, expMask);
        end
        nChecks++;
        if (obsCnt !== LW'($countones(expMask))) begin
            nFails++;
            $display("FAIL %s count: got %0d want %0d", nm, obsCnt,
                     $countones(expMask));
        end
        nChecks++;
        if (obsWid !== LW'(expWidth(expMask))) begin
            nFails++;
            $display("FAIL %s width: got %0d want %0d", nm, obsWid,
                     expWidth(expMask));
        end
        nChecks++;
        if (obsTo !== expTo) begin
            nFails++;
            $display("FAIL %s timeout: got %0b want %0b", nm, obsTo, expTo);
        end
        nChecks++;
        if (lenQ.size() !== expWins) begin
            nFails++;
            $display("FAIL %s windows: got %0d want %0d", nm, lenQ.size(),
                     expWins);
        end else begin
            for (int i = 0; i < expWins; i++) begin
                nChecks++;
                if (lenQ[i] !== expLen[i]) begin
                    nFails++;
                    $display("FAIL %s win_len%0d: got %0d want %0d", nm, i,
                             lenQ[i], expLen[i]);
                end
            end
        end
        nChecks++;
        if (badIdle || badBusy) begin
            nFails++;
            $display("FAIL %s idle_busy: idle_bad %0b busy_bad %0b want 0 0",
                     nm, badIdle, badBusy);
        end
        nChecks++;
        if (busy !== 1'b0 || detected_mask !== obsMask || timeout !== obsTo
            || NumberDetectLanes !== obsCnt) begin
            nFails++;
            $display("FAIL %s hold: busy %0b mask %h to %0b want 0 %h %0b",
                     nm, busy, detected_mask, timeout, obsMask, obsTo);
        end
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        clear_inputs();
        repeat (2) @(posedge pclk);
        #1;
        nChecks++;
        if (busy !== 0 || WriteDetectLanesFlag !== 0 || timeout !== 0) begin
            nFails++;
            $display("FAIL reset_ctl: busy %b flag %b to %b want 0 0 0",
                     busy, WriteDetectLanesFlag, timeout);
        end
        nChecks++;
        if (TxDetectRx_Loopback !== '0 || detected_mask !== '0) begin
            nFails++;
            $display("FAIL reset_lanes: tx %h mask %h want 0 0",
                     TxDetectRx_Loopback, detected_mask);
        end
        nChecks++;
        if (NumberDetectLanes !== '0 || link_width !== '0) begin
            nFails++;
            $display("FAIL reset_count: cnt %0d wid %0d want 0 0",
                     NumberDetectLanes, link_width);
        end
        nChecks++;
        if (TxElecIdle !== '1 || PowerDown !== {L{4'h2}}) begin
            nFails++;
            $display("FAIL reset_idle: elec %h pd %h want ffff 2222..",
                     TxElecIdle, PowerDown);
        end
        reset_n = 1;
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic test_directed();
        set_window(1, -1, 3'b000);
        set_window(2, -1, 3'b000);
        set_window(0, 3, 3'b011);
        run_txn("all_detect", 0, 0, 0);
        set_window(0, 3, 3'b000);
        for (int i = 0; i < 6; i++) rxVal[0][i] = 3'b011;
        run_txn("lanes0_5", 0, 0, 0);
        set_window(0, 3, 3'b011);
        rxVal[0][0] = 3'b000;
        run_txn("lane0_missing", 0, 0, 0);
        set_window(0, -1, 3'b011);
        set_window(1, -1, 3'b011);
        set_window(2, -1, 3'b011);
        run_txn("no_response", 0, 0, 0);
    endtask

    task automatic test_boundary();
        set_window(1, -1, 3'b000);
        set_window(2, -1, 3'b000);
        set_window(0, T - 1, 3'b011);
        run_txn("all_at_limit", 0, 0, 0);
        set_window(0, 2, 3'b011);
        respCyc[0][L-1] = T;
        run_txn("one_late", 0, 1, 0);
        set_window(0, 1, 3'b000);
        set_window(1, 5, 3'b000);
        set_window(2, 0, 3'b011);
        rxVal[2][1] = 3'b111;
        run_txn("retry_then_hit", 0, 1, 0);
    endtask

    task automatic test_restart_idle();
        set_window(0, 4, 3'b011);
        for (int i = 8; i < L; i++) rxVal[0][i] = 3'b010;
        run_txn("restart_as_start", 1, 0, 0);
    endtask

    task automatic test_start_ignored();
        set_window(0, 6, 3'b011);
        respCyc[0][5] = -1;
        run_txn("start_ignored", 0, 1, 1);
    endtask

    task automatic test_random();
        int mode, r;
        for (int t = 0; t < 40; t++) begin
            for (int w = 0; w < 3; w++) begin
                mode = $urandom_range(0, 3);
                for (int i = 0; i < L; i++) begin
                    if (mode == 0) respCyc[w][i] = $urandom_range(0, T - 1);
                    else if ($urandom_range(0, 3) == 0) respCyc[w][i] = -1;
                    else respCyc[w][i] = $urandom_range(0, T + 2);
                    r = $urandom_range(0, 7);
                    if (mode == 1) r = (r == 3) ? 0 : r;
                    else if ($urandom_range(0, 1) == 1) r = 3;
                    rxVal[w][i] = 3'(r);
                end
            end
            run_txn($sformatf("rand%0d", t), t[0], 1, t[1]);
        end
    endtask

    task automatic test_restart_mid();
        int k, k2;
        bit fired, seen;
        clear_inputs();
        @(posedge pclk); #1 start = 1;
        @(posedge pclk); #1 start = 0;
        k = 0; fired = 0;
        for (int c = 0; c < 20 && !fired; c++) begin
            if (TxDetectRx_Loopback[0] === 1'b1) begin
                PhyStatus = '0;
                if (k == 2) begin
                    PhyStatus[2] = 1'b1;
                    RxStatus[8:6] = 3'b011;
                end
                if (k == 4) begin
                    nChecks++;
                    if (detected_mask !== 16'h0004) begin
                        nFails++;
                        $display("FAIL restart_pre: mask %h want 0004",
                                 detected_mask);
                    end
                end
                if (k == 5) begin
                    restart = 1;
                    fired = 1;
                end
                k++;
            end
            @(posedge pclk); #1;
        end
        restart = 0;
        PhyStatus = '0;
        nChecks++;
        if (detected_mask !== '0 || busy !== 1'b1) begin
            nFails++;
            $display("FAIL restart_clear: mask %h busy %b want 0 1",
                     detected_mask, busy);
        end
        k2 = 0; seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            PhyStatus = '0;
            if (WriteDetectLanesFlag === 1'b1) begin
                seen = 1;
                nChecks++;
                if (detected_mask !== 16'h000B || NumberDetectLanes !== 3
                    || link_width !== 2 || timeout !== 0) begin
                    nFails++;
                    $display("FAIL restart_result: mask %h cnt %0d wid %0d to %b want 000b 3 2 0",
                             detected_mask, NumberDetectLanes, link_width,
                             timeout);
                end
            end else if (TxDetectRx_Loopback[0] === 1'b1) begin
                if (k2 == 1) begin
                    PhyStatus = '1;
                    RxStatus = '0;
                    RxStatus[2:0]   = 3'b011;
                    RxStatus[5:3]   = 3'b011;
                    RxStatus[11:9]  = 3'b011;
                end
                k2++;
            end
            if (!seen) begin
                @(posedge pclk); #1;
            end
        end
        nChecks++;
        if (!seen) begin
            nFails++;
            $display("FAIL restart_flag: got no flag want one");
        end
        clear_inputs();
        repeat (3) @(posedge pclk);
        #1;
    endtask

    task automatic test_reset_mid();
        int k;
        bit bad;
        clear_inputs();
        @(posedge pclk); #1 start = 1;
        @(posedge pclk); #1 start = 0;
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            if (TxDetectRx_Loopback[0] === 1'b1) begin
                PhyStatus = '0;
                if (k == 1) begin
                    PhyStatus[3:0] = 4'hF;
                    RxStatus[11:0] = {4{3'b011}};
                end
                k++;
            end
            if (k < 5) begin
                @(posedge pclk); #1;
            end
        end
        PhyStatus = '0;
        nChecks++;
        if (detected_mask !== 16'h000F) begin
            nFails++;
            $display("FAIL reset_mid_pre: mask %h want 000f", detected_mask);
        end
        #2 reset_n = 0;
        #1;
        nChecks++;
        if (TxDetectRx_Loopback !== '0 || detected_mask !== '0
            || busy !== 0 || WriteDetectLanesFlag !== 0 || timeout !== 0
            || NumberDetectLanes !== '0 || link_width !== '0) begin
            nFails++;
            $display("FAIL reset_mid_async: tx %h mask %h busy %b flag %b want all 0",
                     TxDetectRx_Loopback, detected_mask, busy,
                     WriteDetectLanesFlag);
        end
        nChecks++;
        if (TxElecIdle !== '1 || PowerDown !== {L{4'h2}}) begin
            nFails++;
            $display("FAIL reset_mid_idle: elec %h pd %h want ffff 2222..",
                     TxElecIdle, PowerDown);
        end
        bad = 0;
        repeat (3) begin
            @(posedge pclk); #1;
            if (WriteDetectLanesFlag !== 0 || busy !== 0) bad = 1;
        end
        reset_n = 1;
        repeat (25) begin
            @(posedge pclk); #1;
            if (WriteDetectLanesFlag !== 0 || busy !== 0) bad = 1;
        end
        nChecks++;
        if (bad) begin
            nFails++;
            $display("FAIL reset_mid_noflag: got flag/busy activity want none");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_boundary();
        test_restart_idle();
        test_start_ignored();
        test_restart_mid();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pcie_rx_detect_ctrl.md
PCIE_RX_DETECT_CTRL -- requirements
Module: pcie_rx_detect_ctrl

Interface
REQ-001 Parameter LANESNUMBER, default 16, number of PIPE lanes (1..32).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles per detect window.
REQ-003 Parameter MAX_RETRIES, default 2, extra windows allowed when no lane is detected.
REQ-004 Width LW = $clog2(LANESNUMBER)+1 applies to all lane-count outputs.
REQ-005 Clock: pclk, input, 1 bit; all logic is on its rising edge.
REQ-006 Reset: reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 start, input, 1 bit: one-cycle request to begin detection.
REQ-008 restart, input, 1 bit: force-detect; restarts an operation already in progress.
REQ-009 PhyStatus, input, LANESNUMBER bits: per-lane PIPE completion strobe.
REQ-010 RxStatus, input, 3*LANESNUMBER bits: lane i occupies bits [3i+2:3i].
REQ-011 TxDetectRx_Loopback, output, LANESNUMBER bits: per-lane detect request.
REQ-012 TxElecIdle, output, LANESNUMBER bits: per-lane electrical-idle request.
REQ-013 PowerDown, output, 4*LANESNUMBER bits: per-lane power state.
REQ-014 detected_mask, output, LANESNUMBER bits: lanes with a receiver present.
REQ-015 NumberDetectLanes, output, LW bits: population count of detected_mask.
REQ-016 link_width, output, LW bits: usable contiguous power-of-two width.
REQ-017 WriteDetectLanesFlag, output, 1 bit: one-cycle result-valid strobe.
REQ-018 busy, output, 1 bit; timeout, output, 1 bit.

Function
REQ-019 The FSM SHALL have states IDLE, ASSERT, WAIT, EVAL and DONE, with all outputs registered.
REQ-020 In IDLE, a start pulse SHALL move the FSM to ASSERT, clear detected_mask, clear timeout, and clear the retry counter.
REQ-021 start SHALL be ignored when the FSM is not in IDLE.
REQ-022 ASSERT SHALL last 1 cycle and then go to WAIT. TxDetectRx_Loopback SHALL be all ones from the cycle after ASSERT is entered until WAIT exits.
REQ-023 From the start pulse until DONE, TxElecIdle SHALL be all ones and PowerDown SHALL be P1 (4'h2) on every lane.
REQ-024 In WAIT, lane i SHALL be marked responded on the first cycle PhyStatus[i]=1. In that same cycle, detected_mask[i] SHALL be set if RxStatus lane i equals 3'b011, and left clear otherwise.
REQ-025 Later PhyStatus pulses on a lane that has already responded SHALL be ignored within the window.
REQ-026 WAIT SHALL exit to EVAL when every lane has responded or when the window counter reaches TIMEOUT_CYCLES-1, whichever happens first.
REQ-027 On a timeout exit, lanes that did not respond SHALL count as not detected, and the timeout output SHALL be set and held until the next start.
REQ-028 If all lanes respond in the same cycle the counter reaches its limit, the exit SHALL count as all-responded and timeout SHALL remain 0.
REQ-029 In EVAL, if detected_mask==0 and the retry count is below MAX_RETRIES, the FSM SHALL increment the retry count, reset the window counter and go to ASSERT.
REQ-030 In EVAL, in every other case, the FSM SHALL go to DONE.
REQ-031 link_width SHALL be the largest N in {1,2,4,8,16,32} with N<=LANESNUMBER such that lanes 0..N-1 are all detected; if lane 0 is not detected, link_width SHALL be 0.
REQ-032 DONE SHALL last 1 cycle. In that cycle WriteDetectLanesFlag SHALL be 1 and NumberDetectLanes/link_width SHALL be valid; the FSM then returns to IDLE.
REQ-033 detected_mask, NumberDetectLanes and link_width SHALL hold their values until the next start.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 restart=1 in ASSERT, WAIT or EVAL SHALL clear the mask, the responded flags, the retries and the counter, and re-enter ASSERT on the next cycle. restart SHALL take priority over any exit in the same cycle.
REQ-036 restart=1 in IDLE SHALL behave as start.

Reset
REQ-037 While reset_n=0, the FSM SHALL be in IDLE and TxDetectRx_Loopback, detected_mask, NumberDetectLanes, link_width, WriteDetectLanesFlag, busy, timeout and all counters SHALL be 0.
REQ-038 While reset_n=0, TxElecIdle SHALL be all ones and PowerDown SHALL be P1 on every lane.
REQ-039 Reset asserted mid-operation SHALL abort immediately with no WriteDetectLanesFlag pulse.

Structure
REQ-040 The shared package pcie_pkg SHALL hold the state enum, RXSTATUS_DETECTED=3'b011 and POWERDOWN_P1=4'h2.
REQ-041 Population count and link_width derivation SHALL be implemented in the sub-module pcie_lane_width_calc, parametrised by LANESNUMBER.

Verification
REQ-042 LANESNUMBER=16, all lanes give PhyStatus with RxStatus=011 on WAIT cycle 3 -> detected_mask=16'hFFFF, count=16, width=16, a single flag pulse, timeout=0.
REQ-043 Lanes 0-5 give 011 and lanes 6-15 give 000 -> detected_mask=16'h003F, count=6, width=4.
REQ-044 Lanes 1-15 give 011 and lane 0 gives 000 -> detected_mask=16'hFFFE, count=15, width=0.
REQ-045 TIMEOUT_CYCLES=16, MAX_RETRIES=2, no PhyStatus at all -> exactly 3 TxDetectRx windows of 16 cycles each, then flag pulse, mask=0, count=0, timeout=1.
REQ-046 restart asserted on WAIT cycle 5 with lane 2 already marked -> mask cleared, a new window starts, and the final result reflects only the new window.
REQ-047 reset_n driven low on WAIT cycle 4 -> all outputs take their REQ-037/038 values asynchronously and no flag pulse occurs.
